// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the IF/MEM pipeline stages, the shared
// single-ported memory and the arbiter that sits between them.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever surrounds it (pipeline plus memory).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction-fetch requester
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ready_o;
    logic [DATA_W-1:0] if_data_o;

    // load/store requester
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ready_o;
    logic [DATA_W-1:0] dm_rdata_o;

    // shared memory port
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // pipeline freeze
    logic              stall_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i,
        output if_ready_o, if_data_o,
        output dm_ready_o, dm_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i,
        input  if_ready_o, if_data_o,
        input  dm_ready_o, dm_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, single-ported memory between
// instruction fetch (IF) and load/store (DM). Each access occupies the memory
// for LAT cycles; the requester gets a one-cycle ready pulse afterwards.
// Back-to-back grants keep the memory busy with no idle cycle in between.
// stall_o is the only combinational output.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_port_arbiter_if.slave    bus
);

    localparam int              CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_IF = 2'd1,
        ACC_DM = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               last_dm_reg;      // 1: DM held the most recent grant

    logic               if_ready_reg;
    logic [DATA_W-1:0]  if_data_reg;
    logic               dm_ready_reg;
    logic [DATA_W-1:0]  dm_rdata_reg;
    logic               mem_en_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [DATA_W-1:0]  mem_wdata_reg;

    logic               final_edge;
    logic               take_edge;
    logic               if_cand;
    logic               dm_cand;
    logic               grant_if;
    logic               grant_dm;

    // Decide whether this edge may grant, and whom. A requester is not a
    // candidate while its ready pulse is showing, nor at the final edge of its
    // own access (its ready is still one cycle away and its level request is
    // still up), so a held request is never issued twice.
    always_comb begin
        final_edge = 1'b0;
        take_edge  = 1'b0;
        if_cand    = 1'b0;
        dm_cand    = 1'b0;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;

        final_edge = (state_reg != IDLE) && (cnt_reg == CNT_LAST);
        take_edge  = (state_reg == IDLE) || final_edge;

        if_cand = bus.if_req_i & ~if_ready_reg & (state_reg != ACC_IF);
        dm_cand = bus.dm_req_i & ~dm_ready_reg & (state_reg != ACC_DM);

        // On contention the side that did not win last time goes next.
        grant_dm = take_edge & dm_cand & (~if_cand | ~last_dm_reg);
        grant_if = take_edge & if_cand & ~grant_dm;
    end

    // Access sequencer: state, cycle counter, round-robin memory and all
    // registered outputs move together here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            last_dm_reg   <= 1'b0;
            if_ready_reg  <= 1'b0;
            if_data_reg   <= '0;
            dm_ready_reg  <= 1'b0;
            dm_rdata_reg  <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            // ready is a single-cycle pulse unless re-armed below
            if_ready_reg <= 1'b0;
            dm_ready_reg <= 1'b0;

            if (final_edge) begin
                // read data is valid in the last access cycle only
                if (state_reg == ACC_IF) begin
                    if_data_reg  <= bus.mem_rdata_i;
                    if_ready_reg <= 1'b1;
                end else begin
                    if (!mem_we_reg) begin
                        dm_rdata_reg <= bus.mem_rdata_i;
                    end
                    dm_ready_reg <= 1'b1;
                end
            end

            if (take_edge) begin
                cnt_reg <= '0;
                if (grant_dm) begin
                    state_reg     <= ACC_DM;
                    last_dm_reg   <= 1'b1;
                    mem_en_reg    <= 1'b1;
                    mem_we_reg    <= bus.dm_we_i;
                    mem_addr_reg  <= bus.dm_addr_i;
                    mem_wdata_reg <= bus.dm_wdata_i;
                end else if (grant_if) begin
                    state_reg     <= ACC_IF;
                    last_dm_reg   <= 1'b0;
                    mem_en_reg    <= 1'b1;
                    mem_we_reg    <= 1'b0;
                    mem_addr_reg  <= bus.if_addr_i;
                end else begin
                    // nothing pending: release the memory, keep address/data
                    state_reg  <= IDLE;
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign bus.if_ready_o  = if_ready_reg;
    assign bus.if_data_o   = if_data_reg;
    assign bus.dm_ready_o  = dm_ready_reg;
    assign bus.dm_rdata_o  = dm_rdata_reg;
    assign bus.mem_en_o    = mem_en_reg;
    assign bus.mem_we_o    = mem_we_reg;
    assign bus.mem_addr_o  = mem_addr_reg;
    assign bus.mem_wdata_o = mem_wdata_reg;

    // Freeze while anyone waits; drops in the ready cycle so the pipeline
    // advances exactly once per completed access.
    assign bus.stall_o = (bus.if_req_i & ~if_ready_reg) |
                         (bus.dm_req_i & ~dm_ready_reg);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LAT=2. The memory model returns
// mem_addr_o ^ KEY, so every expected read value is a hand-computed constant.
module tb_mem_port_arbiter;

    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 32;
    localparam int          LAT    = 2;
    localparam logic [31:0] KEY    = 32'h8C01_0044;

    logic clk;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // memory: read data is a fixed function of the presented address
    assign bus.mem_rdata_i = bus.mem_addr_o ^ KEY;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_mem_en"},    64'(bus.mem_en_o),    64'd0);
        chk({tag, "_mem_we"},    64'(bus.mem_we_o),    64'd0);
        chk({tag, "_mem_addr"},  64'(bus.mem_addr_o),  64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata_o), 64'd0);
        chk({tag, "_if_ready"},  64'(bus.if_ready_o),  64'd0);
        chk({tag, "_if_data"},   64'(bus.if_data_o),   64'd0);
        chk({tag, "_dm_ready"},  64'(bus.dm_ready_o),  64'd0);
        chk({tag, "_dm_rdata"},  64'(bus.dm_rdata_o),  64'd0);
    endtask

    // advance through one active edge, land mid-cycle on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int   pulses;
        int   cyc;
        int   idle;
        logic exp_dm;

        rst            = 1'b1;
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.dm_req_i   = 1'b0;
        bus.dm_we_i    = 1'b0;
        bus.dm_addr_i  = '0;
        bus.dm_wdata_i = '0;

        // ---- reset state, then quiet idle ----
        @(negedge clk);
        chk_cleared("por");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("idle_en%0d", i),    64'(bus.mem_en_o), 64'd0);
            chk($sformatf("idle_stall%0d", i), 64'(bus.stall_o),  64'd0);
        end

        // ---- single fetch, address change mid-access ignored ----
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h40;
        #1 chk("f_stall_c0", 64'(bus.stall_o), 64'd1);
        step();                                              // cycle 1
        chk("f_en_c1",    64'(bus.mem_en_o),   64'd1);
        chk("f_we_c1",    64'(bus.mem_we_o),   64'd0);
        chk("f_addr_c1",  64'(bus.mem_addr_o), 64'h40);
        chk("f_stall_c1", 64'(bus.stall_o),    64'd1);
        bus.if_addr_i = 32'h80;
        step();                                              // cycle 2
        chk("f_en_c2",    64'(bus.mem_en_o),   64'd1);
        chk("f_addr_c2",  64'(bus.mem_addr_o), 64'h40);
        chk("f_rdy_c2",   64'(bus.if_ready_o), 64'd0);
        chk("f_stall_c2", 64'(bus.stall_o),    64'd1);
        step();                                              // cycle 3
        chk("f_rdy_c3",   64'(bus.if_ready_o), 64'd1);
        chk("f_data_c3",  64'(bus.if_data_o),  64'h8C01_0004);
        chk("f_stall_c3", 64'(bus.stall_o),    64'd0);
        chk("f_en_c3",    64'(bus.mem_en_o),   64'd0);
        $display("txn IF  addr=0x40 data=0x%08h", bus.if_data_o);
        bus.if_req_i = 1'b0;
        step();                                              // cycle 4
        chk("f_rdy_c4",  64'(bus.if_ready_o), 64'd0);
        chk("f_hold_c4", 64'(bus.if_data_o),  64'h8C01_0004);

        // ---- mid-run reset clears everything at once, then contention ----
        rst = 1'b1;
        #1 chk_cleared("rst3");
        #2 rst = 1'b0;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        bus.dm_req_i  = 1'b1;
        bus.dm_we_i   = 1'b0;
        bus.dm_addr_i = 32'h200;
        #1 chk("b_stall_c0", 64'(bus.stall_o), 64'd1);
        step();                                              // cycle 1
        chk("b_en_c1",   64'(bus.mem_en_o),   64'd1);
        chk("b_addr_c1", 64'(bus.mem_addr_o), 64'h200);
        chk("b_we_c1",   64'(bus.mem_we_o),   64'd0);
        step();                                              // cycle 2
        chk("b_en_c2",    64'(bus.mem_en_o),   64'd1);
        chk("b_addr_c2",  64'(bus.mem_addr_o), 64'h200);
        chk("b_dmrdy_c2", 64'(bus.dm_ready_o), 64'd0);
        step();                                              // cycle 3
        chk("b_dmrdy_c3", 64'(bus.dm_ready_o), 64'd1);
        chk("b_dmdat_c3", 64'(bus.dm_rdata_o), 64'h8C01_0244);
        chk("b_en_c3",    64'(bus.mem_en_o),   64'd1);
        chk("b_addr_c3",  64'(bus.mem_addr_o), 64'h100);
        chk("b_stall_c3", 64'(bus.stall_o),    64'd1);
        $display("txn DM  addr=0x200 rdata=0x%08h", bus.dm_rdata_o);
        bus.dm_req_i = 1'b0;
        step();                                              // cycle 4
        chk("b_en_c4",    64'(bus.mem_en_o),   64'd1);
        chk("b_addr_c4",  64'(bus.mem_addr_o), 64'h100);
        chk("b_dmrdy_c4", 64'(bus.dm_ready_o), 64'd0);
        chk("b_ifrdy_c4", 64'(bus.if_ready_o), 64'd0);
        step();                                              // cycle 5
        chk("b_ifrdy_c5", 64'(bus.if_ready_o), 64'd1);
        chk("b_ifdat_c5", 64'(bus.if_data_o),  64'h8C01_0144);
        chk("b_en_c5",    64'(bus.mem_en_o),   64'd0);
        chk("b_stall_c5", 64'(bus.stall_o),    64'd0);
        $display("txn IF  addr=0x100 data=0x%08h", bus.if_data_o);
        bus.if_req_i = 1'b0;
        step();

        // ---- both held: strict DM/IF alternation, no idle cycle ----
        bus.if_addr_i = 32'h500;
        bus.dm_addr_i = 32'h600;
        bus.dm_we_i   = 1'b0;
        bus.if_req_i  = 1'b1;
        bus.dm_req_i  = 1'b1;
        pulses = 0;
        cyc    = 0;
        idle   = 0;
        exp_dm = 1'b1;
        while (pulses < 20 && cyc < 200) begin
            step();
            cyc++;
            if (!bus.mem_en_o) idle++;
            if (bus.dm_ready_o || bus.if_ready_o) begin
                chk($sformatf("rr_kind%0d", pulses), 64'({bus.dm_ready_o, bus.if_ready_o}),
                    exp_dm ? 64'd2 : 64'd1);
                if (exp_dm) begin
                    chk($sformatf("rr_dmdat%0d", pulses), 64'(bus.dm_rdata_o), 64'h8C01_0644);
                    $display("txn DM  #%0d addr=0x600 rdata=0x%08h", pulses, bus.dm_rdata_o);
                end else begin
                    chk($sformatf("rr_ifdat%0d", pulses), 64'(bus.if_data_o), 64'h8C01_0544);
                    $display("txn IF  #%0d addr=0x500 data=0x%08h", pulses, bus.if_data_o);
                end
                exp_dm = ~exp_dm;
                pulses++;
            end
        end
        chk("rr_count",   64'(pulses), 64'd20);
        chk("rr_no_idle", 64'(idle),   64'd0);
        bus.if_req_i = 1'b0;
        bus.dm_req_i = 1'b0;
        repeat (4) step();
        chk("rr_drain_en",    64'(bus.mem_en_o), 64'd0);
        chk("rr_drain_stall", 64'(bus.stall_o),  64'd0);

        // ---- store: write enable and data held, load data untouched ----
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h10;
        bus.dm_wdata_i = 32'hDEAD_BEEF;
        step();                                              // cycle 1
        chk("s_en_c1",    64'(bus.mem_en_o),    64'd1);
        chk("s_we_c1",    64'(bus.mem_we_o),    64'd1);
        chk("s_addr_c1",  64'(bus.mem_addr_o),  64'h10);
        chk("s_wdata_c1", 64'(bus.mem_wdata_o), 64'hDEAD_BEEF);
        bus.dm_addr_i  = 32'h20;
        bus.dm_wdata_i = 32'h1234_5678;
        step();                                              // cycle 2
        chk("s_we_c2",    64'(bus.mem_we_o),    64'd1);
        chk("s_addr_c2",  64'(bus.mem_addr_o),  64'h10);
        chk("s_wdata_c2", 64'(bus.mem_wdata_o), 64'hDEAD_BEEF);
        chk("s_rdy_c2",   64'(bus.dm_ready_o),  64'd0);
        step();                                              // cycle 3
        chk("s_rdy_c3",   64'(bus.dm_ready_o),  64'd1);
        chk("s_rdata_c3", 64'(bus.dm_rdata_o),  64'h8C01_0644);
        chk("s_en_c3",    64'(bus.mem_en_o),    64'd0);
        chk("s_we_c3",    64'(bus.mem_we_o),    64'd0);
        $display("txn ST  addr=0x10 wdata=0xdeadbeef");
        bus.dm_req_i = 1'b0;
        bus.dm_we_i  = 1'b0;
        step();

        // ---- reset in cycle 1 of a fetch abandons it; re-request completes ----
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h300;
        step();                                              // cycle 1
        chk("r_en_c1", 64'(bus.mem_en_o), 64'd1);
        rst = 1'b1;
        #1 chk_cleared("rst6");
        bus.if_req_i = 1'b0;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("r_norody%0d", i), 64'(bus.if_ready_o), 64'd0);
            chk($sformatf("r_noen%0d", i),   64'(bus.mem_en_o),   64'd0);
        end
        bus.if_req_i = 1'b1;
        step();                                              // cycle 1
        chk("r2_en_c1", 64'(bus.mem_en_o),   64'd1);
        chk("r2_addr",  64'(bus.mem_addr_o), 64'h300);
        step();                                              // cycle 2
        chk("r2_en_c2", 64'(bus.mem_en_o),   64'd1);
        step();                                              // cycle 3
        chk("r2_rdy",   64'(bus.if_ready_o), 64'd1);
        chk("r2_data",  64'(bus.if_data_o),  64'h8C01_0344);
        $display("txn IF  addr=0x300 data=0x%08h (after reset)", bus.if_data_o);
        bus.if_req_i = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
